// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the data-memory port: fixed priority to requester 0 with
// starvation protection for requester 1, plus an ID FIFO that routes in-order responses.
module dmem_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MASK_W          = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,

    input  logic                               m0_req,
    input  logic                               m0_we,
    input  logic [ADDR_W-1:0]                  m0_a,
    input  logic [DATA_W-1:0]                  m0_wd,
    input  logic [MASK_W-1:0]                  m0_wmask,
    output logic                               m0_gnt,
    output logic                               m0_rvalid,
    output logic [DATA_W-1:0]                  m0_rd,

    input  logic                               m1_req,
    input  logic                               m1_we,
    input  logic [ADDR_W-1:0]                  m1_a,
    input  logic [DATA_W-1:0]                  m1_wd,
    input  logic [MASK_W-1:0]                  m1_wmask,
    output logic                               m1_gnt,
    output logic                               m1_rvalid,
    output logic [DATA_W-1:0]                  m1_rd,

    output logic                               mem_req,
    output logic                               mem_we,
    output logic [ADDR_W-1:0]                  mem_a,
    output logic [DATA_W-1:0]                  mem_wd,
    output logic [MASK_W-1:0]                  mem_wmask,
    input  logic                               mem_gnt,
    input  logic                               mem_rvalid,
    input  logic [DATA_W-1:0]                  mem_rd,

    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               proto_err
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [MAX_OUTSTANDING-1:0] id_fifo;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [STV_W-1:0]           starve_cnt;
    logic                       starved;
    logic                       sel;
    logic                       has_room;
    logic                       push;
    logic                       pop;
    logic                       pop_id;

    assign starved  = (starve_cnt == STV_W'(STARVE_LIMIT));
    assign sel      = m1_req && (!m0_req || starved);
    // Room is judged from the registered count; a pop in the same cycle does not free a slot.
    assign has_room = (outstanding < CNT_W'(MAX_OUTSTANDING));

    always_comb begin
        mem_req   = rst_n && (m0_req || m1_req) && has_room;
        mem_we    = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;
        mem_wmask = '0;
        if (mem_req) begin
            if (sel) begin
                mem_we    = m1_we;
                mem_a     = m1_a;
                mem_wd    = m1_wd;
                mem_wmask = m1_wmask;
            end else begin
                mem_we    = m0_we;
                mem_a     = m0_a;
                mem_wd    = m0_wd;
                mem_wmask = m0_wmask;
            end
        end
    end

    assign m0_gnt    = mem_req && mem_gnt && !sel;
    assign m1_gnt    = mem_req && mem_gnt && sel;
    assign push      = m0_gnt || m1_gnt;
    assign pop       = mem_rvalid && (outstanding != '0);
    assign pop_id    = id_fifo[rd_ptr];
    assign m0_rvalid = pop && !pop_id;
    assign m1_rvalid = pop && pop_id;
    assign m0_rd     = m0_rvalid ? mem_rd : '0;
    assign m1_rd     = m1_rvalid ? mem_rd : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_fifo     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            starve_cnt  <= '0;
            proto_err   <= 1'b0;
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= m1_gnt;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (mem_rvalid && (outstanding == '0)) begin
                proto_err <= 1'b1;
            end
            if (m1_req && !m1_gnt) begin
                if (!starved) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with a response scoreboard.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int MO = 4;
    localparam int SL = 8;

    logic          clk;
    logic          rst_n;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_a;
    logic [DW-1:0] m0_wd, m0_rd;
    logic [MW-1:0] m0_wmask;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_a;
    logic [DW-1:0] m1_wd, m1_rd;
    logic [MW-1:0] m1_wmask;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;
    logic [MW-1:0] mem_wmask;
    logic [2:0]    outstanding;
    logic          proto_err;

    int total = 0;
    int bad   = 0;
    logic [DW:0] exp_q[$];
    logic [DW:0] e;
    int prev_id;
    int exp_id;

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
        .MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_a(m0_a), .m0_wd(m0_wd), .m0_wmask(m0_wmask),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_we(m1_we), .m1_a(m1_a), .m1_wd(m1_wd), .m1_wmask(m1_wmask),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rd(mem_rd),
        .outstanding(outstanding), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory returns data for an earlier grant; the owner and data are queued as expected.
    task automatic respond(input int id, input logic [DW-1:0] d);
        mem_rvalid = 1'b1;
        mem_rd     = d;
        exp_q.push_back({id[0], d});
    endtask

    always @(negedge clk) begin
        if (rst_n && (m0_rvalid || m1_rvalid)) begin
            if (m0_rvalid && m1_rvalid) begin
                check("rsp_both", {m1_rvalid, m0_rvalid}, 2'b01);
            end else if (exp_q.size() == 0) begin
                check("rsp_unexpected", {m1_rvalid, m0_rvalid}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id", m1_rvalid, e[DW]);
                check("rsp_data", m1_rvalid ? m1_rd : m0_rd, e[DW-1:0]);
                check("rsp_other_rd", m1_rvalid ? m0_rd : m1_rd, 0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_a = '0; m0_wd = '0; m0_wmask = '0;
        m1_req = 0; m1_we = 0; m1_a = '0; m1_wd = '0; m1_wmask = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rd = '0;

        // Reset: requests are ignored while reset is held
        m0_req = 1; mem_gnt = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outstanding", outstanding, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_gnt", {m1_gnt, m0_gnt}, 0);
        m0_req = 0;
        rst_n  = 1;
        cyc();

        // Single read
        m0_req = 1; m0_we = 0; m0_a = 32'h100;
        @(negedge clk);
        check("rd_gnt", {m1_gnt, m0_gnt}, 2'b01);
        check("rd_mem_req", mem_req, 1);
        check("rd_mem_a", mem_a, 32'h100);
        check("rd_mem_we", mem_we, 0);
        check("rd_out0", outstanding, 0);
        cyc();
        m0_req = 0;
        @(negedge clk);
        check("rd_out1", outstanding, 1);
        check("rd_no_rvalid", {m1_rvalid, m0_rvalid}, 0);
        cyc();
        respond(0, 32'hDEADBEEF);
        @(negedge clk);
        check("rd_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
        cyc();
        mem_rvalid = 0;
        @(negedge clk);
        check("rd_out_back0", outstanding, 0);

        // Memory stall: requester 1 saturates the starvation counter and takes the port
        cyc();
        m0_req = 1; m0_we = 0; m0_a = 32'h200;
        m1_req = 1; m1_we = 1; m1_a = 32'h300; m1_wd = 32'h12345678; m1_wmask = 4'b0101;
        mem_gnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_no_gnt", {m1_gnt, m0_gnt}, 0);
            check("stall_mem_req", mem_req, 1);
            check("stall_mem_a", mem_a, (k >= SL) ? 32'h300 : 32'h200);
            cyc();
        end
        mem_gnt = 1;
        @(negedge clk);
        check("starve_m1_gnt", {m1_gnt, m0_gnt}, 2'b10);
        check("starve_mem_we", mem_we, 1);
        check("starve_mem_wd", mem_wd, 32'h12345678);
        check("starve_mem_wmask", mem_wmask, 4'b0101);
        cyc();
        m1_req = 0;
        @(negedge clk);
        check("starve_m0_after", {m1_gnt, m0_gnt}, 2'b01);
        cyc();
        m0_req = 0;
        respond(1, 32'h11);
        @(negedge clk);
        check("starve_out2", outstanding, 2);
        check("starve_rsp1", {m1_rvalid, m0_rvalid}, 2'b10);
        cyc();
        respond(0, 32'h22);
        @(negedge clk);
        check("starve_rsp0", {m1_rvalid, m0_rvalid}, 2'b01);
        cyc();
        mem_rvalid = 0;

        // Contention with memory answering one cycle after each grant
        m0_req = 1; m0_a = 32'h400;
        m1_req = 1; m1_we = 0; m1_a = 32'h500;
        prev_id = -1;
        for (int k = 0; k < 18; k++) begin
            exp_id = (k == SL || k == 2 * SL + 1) ? 1 : 0;
            if (prev_id >= 0) respond(prev_id, 32'h1000 + k);
            @(negedge clk);
            check("cont_gnt", {m1_gnt, m0_gnt}, (exp_id == 1) ? 2'b10 : 2'b01);
            check("cont_out", outstanding, (k == 0) ? 0 : 1);
            if (prev_id >= 0)
                check("cont_rvalid", {m1_rvalid, m0_rvalid}, (prev_id == 1) ? 2'b10 : 2'b01);
            prev_id = exp_id;
            cyc();
        end
        m0_req = 0; m1_req = 0;
        respond(prev_id, 32'h2000);
        @(negedge clk);
        cyc();
        mem_rvalid = 0;
        @(negedge clk);
        check("cont_out_end", outstanding, 0);

        // Full: four grants fill the FIFO; a same-cycle response does not free a slot
        cyc();
        m0_req = 1; m0_a = 32'h600;
        for (int k = 0; k < MO; k++) begin
            @(negedge clk);
            check("full_gnt", {m1_gnt, m0_gnt}, 2'b01);
            check("full_out", outstanding, k);
            cyc();
        end
        respond(0, 32'hA0);
        @(negedge clk);
        check("full_mem_req", mem_req, 0);
        check("full_no_gnt", {m1_gnt, m0_gnt}, 0);
        check("full_out4", outstanding, MO);
        check("full_mem_a_zero", mem_a, 0);
        check("full_rvalid", {m1_rvalid, m0_rvalid}, 2'b01);
        cyc();
        mem_rvalid = 0;
        @(negedge clk);
        check("full_resume_gnt", {m1_gnt, m0_gnt}, 2'b01);
        check("full_out3", outstanding, 3);
        cyc();
        m0_req = 0;
        for (int k = 0; k < MO; k++) begin
            respond(0, 32'hA1 + k);
            @(negedge clk);
            check("full_drain", {m1_rvalid, m0_rvalid}, 2'b01);
            cyc();
        end
        mem_rvalid = 0;
        @(negedge clk);
        check("full_out_end", outstanding, 0);

        // Interleaved routing with a push+pop cycle at outstanding=2
        cyc();
        m0_req = 1; m0_a = 32'h10;
        @(negedge clk);
        check("il_gnt0", {m1_gnt, m0_gnt}, 2'b01);
        check("il_a0", mem_a, 32'h10);
        cyc();
        m0_req = 0; m1_req = 1; m1_a = 32'h20;
        @(negedge clk);
        check("il_gnt1", {m1_gnt, m0_gnt}, 2'b10);
        check("il_a1", mem_a, 32'h20);
        cyc();
        m1_req = 0; m0_req = 1; m0_a = 32'h30;
        respond(0, 32'h1);
        @(negedge clk);
        check("il_gnt2", {m1_gnt, m0_gnt}, 2'b01);
        check("il_a2", mem_a, 32'h30);
        check("il_out_pre", outstanding, 2);
        cyc();
        m0_req = 0;
        respond(1, 32'h2);
        @(negedge clk);
        check("il_out_pushpop", outstanding, 2);
        check("il_rsp1", {m1_rvalid, m0_rvalid}, 2'b10);
        cyc();
        respond(0, 32'h3);
        @(negedge clk);
        check("il_rsp2", {m1_rvalid, m0_rvalid}, 2'b01);
        cyc();
        mem_rvalid = 0;
        @(negedge clk);
        check("il_out_end", outstanding, 0);

        // Spurious response, then asynchronous reset mid-cycle
        cyc();
        mem_rvalid = 1; mem_rd = 32'hBAD;
        @(negedge clk);
        check("sp_no_rvalid", {m1_rvalid, m0_rvalid}, 0);
        check("sp_err_pre", proto_err, 0);
        cyc();
        mem_rvalid = 0;
        @(negedge clk);
        check("sp_err_set", proto_err, 1);
        cyc();
        m0_req = 1; m0_a = 32'h700;
        @(negedge clk);
        check("sp_gnt", {m1_gnt, m0_gnt}, 2'b01);
        cyc();
        m0_req = 0;
        @(negedge clk);
        check("sp_err_sticky", proto_err, 1);
        check("sp_out1", outstanding, 1);
        #2;
        rst_n = 0;
        #1;
        check("arst_err", proto_err, 0);
        check("arst_out", outstanding, 0);
        check("arst_mem_req", mem_req, 0);
        cyc();
        rst_n = 1;
        cyc();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters on the data-memory bus.
- Requester 0 is the core's data-memory stage. Requester 1 is a secondary master, such as debug or DMA.
- Arbitration is fixed priority with starvation protection.
- Supports pipelined, in-order memory transactions with up to MAX_OUTSTANDING in flight. An ID FIFO routes each response back to the requester that issued it.

Parameters:
- ADDR_W, 32, address width (`MEM_ADDR_BUS).
- DATA_W, 32, data width (`MEM_DATA_BUS).
- MASK_W, 4, byte write-mask width (`MEM_WMASK_BUS).
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions; power of 2, at least 2.
- STARVE_LIMIT, 8, consecutive cycles requester 1 may be denied before it is forced to win; at least 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mN_req  in  1  request from requester N (N=0,1); held until mN_gnt.
- mN_we  in  1  1 = write, 0 = read.
- mN_a  in  ADDR_W  byte address.
- mN_wd  in  DATA_W  write data.
- mN_wmask  in  MASK_W  byte enables for writes.
- mN_gnt  out  1  request accepted this cycle.
- mN_rvalid  out  1  response for requester N this cycle.
- mN_rd  out  DATA_W  read data; valid only with mN_rvalid.
- mem_req  out  1  request to memory.
- mem_we  out  1  forwarded write enable.
- mem_a  out  ADDR_W  forwarded address.
- mem_wd  out  DATA_W  forwarded write data.
- mem_wmask  out  MASK_W  forwarded byte enables.
- mem_gnt  in  1  memory accepts the current request.
- mem_rvalid  in  1  one response per accepted request (reads and writes), in order.
- mem_rd  in  DATA_W  response data.
- outstanding  out  clog2(MAX_OUTSTANDING)+1  current number of in-flight transactions.
- proto_err  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - ID FIFO empty, outstanding=0, starvation counter=0, proto_err=0.
  - All gnt/rvalid outputs are 0 and mem_req=0.
- Selection (combinational):
  - sel=1 if m1_req && (!m0_req || starve_cnt==STARVE_LIMIT); otherwise sel=0.
- Request path (combinational):
  - mem_req = (m0_req || m1_req) && (outstanding < MAX_OUTSTANDING).
  - The "full" check uses the registered count only. A same-cycle pop does not free a slot.
  - mem_we/a/wd/wmask mux from the selected requester. They are 0 when mem_req=0.
- Grant:
  - mN_gnt = mem_req && mem_gnt && (sel==N). At most one grant per cycle.
  - Zero-cycle latency from mem_gnt to mN_gnt.
- Starvation counter:
  - Increments each cycle m1_req=1 and m1_gnt=0, saturating at STARVE_LIMIT.
  - Clears on m1_gnt or when m1_req=0.
  - While saturated and the memory stalls (mem_gnt=0 or FIFO full), sel stays 1 until requester 1 is granted.
- Push: on any grant, the requester ID is pushed into the ID FIFO and outstanding increments.
- Pop and response routing:
  - On mem_rvalid with the FIFO non-empty, the head ID is popped, outstanding decrements, and mID_rvalid=1 with mID_rd=mem_rd in the same cycle.
  - The non-selected mN_rd is 0.
  - Simultaneous push and pop: outstanding unchanged; FIFO pointers both advance.
- Protocol error:
  - mem_rvalid with the FIFO empty: response dropped (no rvalid to either requester), proto_err set.
  - proto_err is cleared only by reset.
- Pointer wrap: FIFO pointers wrap modulo MAX_OUTSTANDING. Full/empty is derived from outstanding, not from pointer equality.
- Requester obligations:
  - A requester may drop mN_req without a grant; there is no side effect beyond clearing or holding the starvation counter as above.
  - Request fields must be stable while mN_req=1 and not granted.
- Reset mid-operation: in-flight responses are forgotten. Any mem_rvalid after reset sets proto_err. The integrator must reset the memory with the arbiter.
- Registered state: FIFO, pointers, outstanding, starve_cnt, proto_err. No other internal latency.

Test Plan:
- Single read: m0 read a=0x100, mem_gnt=1, mem_rvalid 2 cycles later with rd=0xDEADBEEF -> m0_gnt in cycle 0; m0_rvalid=1, m0_rd=0xDEADBEEF in cycle 2; outstanding 0→1→0.
- Contention: m0_req and m1_req held continuously, mem_gnt=1, STARVE_LIMIT=8 -> m0 granted for 8 cycles, m1 granted in cycle 9, then m0 resumes; starve_cnt returns to 0.
- Full: 4 back-to-back m0 grants with no mem_rvalid -> mem_req=0 in cycle 5 with outstanding=4. Response in cycle 5 -> no grant that cycle, grant resumes in cycle 6.
- Interleaved routing: grants in order m0 (a=0x10), m1 (a=0x20), m0 (a=0x30); responses 0x1, 0x2, 0x3 -> m0_rvalid, then m1_rvalid, then m0_rvalid, each carrying its matching data.
- Push+pop same cycle at outstanding=2 -> outstanding stays 2, subsequent response order preserved.
- Spurious response: mem_rvalid with outstanding=0 -> no mN_rvalid, proto_err=1 and stays 1. Assert rst_n=0 mid-cycle -> proto_err=0 and outstanding=0 immediately, without waiting for a clock edge.
